// File: rtl/clock_gate_ctrl_pkg.sv
// Shared definitions for the gated-clock enable controller: state encodings
// and the settle-interval clamp.
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_START = 2'd1,
    ST_ON    = 2'd2,
    ST_STOP  = 2'd3
  } cg_state_e;

  // A zero-cycle settle interval is not meaningful; it is clamped up to this.
  localparam int unsigned SETTLE_MIN = 1;

  function automatic int unsigned settle_eff(input int unsigned cycles);
    return (cycles < SETTLE_MIN) ? SETTLE_MIN : cycles;
  endfunction

endpackage

// File: rtl/clock_gate_ctrl_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module cg_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             c,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge c or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Sequences the CE pin of a gated global clock buffer: start/stop on request
// or activity, settle intervals around each CE edge, idle-timeout auto-stop.
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned IDLE_TIMEOUT  = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic c,
  input  logic clr,
  input  logic req_on,
  input  logic wake,
  input  logic busy,
  output logic ce,
  output logic running,
  output logic ack
);

  localparam int unsigned      SETTLE     = settle_eff(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SCNT_LOAD  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_TIMEOUT);

  cg_state_e        state;
  logic             wake_pend;
  logic [CNT_W-1:0] icnt;

  logic scnt_zero_c;
  logic idle_c;
  logic start_go_c;
  logic stop_go_c;
  logic scnt_load_c;
  logic scnt_dec_c;

  assign idle_c      = !req_on && !busy && !wake;
  assign start_go_c  = (state == ST_OFF) && (req_on || wake || wake_pend);
  assign stop_go_c   = (state == ST_ON) && idle_c && (icnt == IDLE_LIMIT);
  assign scnt_load_c = start_go_c || stop_go_c;
  assign scnt_dec_c  = (state == ST_START) || (state == ST_STOP);

  // Settle interval timer, reloaded on every CE toggle.
  cg_down_counter #(
    .CNT_W (CNT_W)
  ) u_scnt (
    .c        (c),
    .clr      (clr),
    .load     (scnt_load_c),
    .dec      (scnt_dec_c),
    .load_val (SCNT_LOAD),
    .zero_c   (scnt_zero_c)
  );

  // CE only changes on OFF->START and ON->STOP, so it stays glitch-free.
  always_ff @(posedge c or posedge clr) begin
    if (clr) begin
      state     <= ST_OFF;
      ce        <= 1'b0;
      running   <= 1'b0;
      ack       <= 1'b0;
      icnt      <= '0;
      wake_pend <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_OFF: begin
          if (start_go_c) begin
            state     <= ST_START;
            ce        <= 1'b1;
            wake_pend <= 1'b0;
          end
        end
        ST_START: begin
          if (scnt_zero_c) begin
            state   <= ST_ON;
            running <= 1'b1;
            ack     <= 1'b1;
            icnt    <= '0;
          end
        end
        ST_ON: begin
          if (!idle_c) begin
            icnt <= '0;
          end else if (stop_go_c) begin
            state   <= ST_STOP;
            ce      <= 1'b0;
            running <= 1'b0;
          end else if (icnt != '1) begin
            icnt <= icnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Requests arriving mid-stop are remembered and replayed from OFF.
          if (req_on || wake) begin
            wake_pend <= 1'b1;
          end
          if (scnt_zero_c) begin
            state <= ST_OFF;
            ack   <= 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized self-checking bench for clock_gate_ctrl against a timestamp-based
// reference model (CE toggle edge + elapsed edges determine every output).
module tb_clock_gate_ctrl;

  localparam int S = 4;   // effective settle interval
  localparam int T = 16;  // idle timeout

  logic c = 1'b0;
  logic clr, req_on, wake, busy;
  logic ce, running, ack;

  int tests = 0;
  int fails = 0;

  // Reference model: CE level, edge index of the last CE toggle, idle run length.
  int n = 0;
  int t_tog = -100000;
  bit m_ce = 1'b0;
  bit m_pend = 1'b0;
  int idle_run = 0;
  bit prev_ack = 1'b0;

  clock_gate_ctrl #(
    .SETTLE_CYCLES (4),
    .IDLE_TIMEOUT  (16),
    .CNT_W         (8)
  ) dut (
    .c       (c),
    .clr     (clr),
    .req_on  (req_on),
    .wake    (wake),
    .busy    (busy),
    .ce      (ce),
    .running (running),
    .ack     (ack)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    t_tog    = n - 100000;
    m_ce     = 1'b0;
    m_pend   = 1'b0;
    idle_run = 0;
  endtask

  task automatic model_edge(input bit r, input bit w, input bit b);
    int age;
    n++;
    age = n - t_tog;
    if (!m_ce) begin
      if (age <= S) begin
        if (r || w) m_pend = 1'b1;
      end else if (r || w || m_pend) begin
        m_ce   = 1'b1;
        t_tog  = n;
        m_pend = 1'b0;
      end
    end else begin
      if (age == S) begin
        idle_run = 0;
      end else if (age > S) begin
        if (r || w || b) idle_run = 0;
        else if (idle_run == T) begin
          m_ce  = 1'b0;
          t_tog = n;
        end else idle_run++;
      end
    end
  endtask

  task automatic step(input bit r, input bit w, input bit b);
    int exp_run;
    int exp_ack;
    @(negedge c);
    req_on = r;
    wake   = w;
    busy   = b;
    @(posedge c);
    model_edge(r, w, b);
    #1;
    exp_run = (m_ce && (n - t_tog) >= S) ? 1 : 0;
    exp_ack = ((n - t_tog) == S) ? 1 : 0;
    chk("ce", 32'(ce), m_ce ? 1 : 0);
    chk("running", 32'(running), exp_run);
    chk("ack", 32'(ack), exp_ack);
    chk("run_without_ce", 32'(running & ~ce), 0);
    chk("ack_back_to_back", 32'(ack & prev_ack), 0);
    prev_ack = ack;
  endtask

  initial begin
    int lat;
    int mode;
    bit r, w, b;

    clr = 1'b1; req_on = 1'b0; wake = 1'b0; busy = 1'b0;
    repeat (3) @(posedge c);
    #1;
    chk("reset_ce", 32'(ce), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_ack", 32'(ack), 0);
    @(negedge c);
    clr = 1'b0;
    model_reset();

    // Start latency: CE right after the request edge, RUNNING+ACK 4 edges later.
    step(1'b1, 1'b0, 1'b0);
    chk("start_ce_now", 32'(ce), 1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("start_not_yet_running", 32'(running), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("start_running", 32'(running), 1);
    chk("start_ack", 32'(ack), 1);
    repeat (5) step(1'b1, 1'b0, 1'b0);

    // Idle stop latency: CE drops after the 17th consecutive idle edge.
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (!ce && lat == 0) lat = k;
    end
    chk("stop_latency", lat, T + 1);

    // Timer restart via WAKE, then BUSY hold blocking auto-stop.
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    chk("wake_restart_holds", 32'(ce), 1);
    repeat (100) step(1'b0, 1'b0, 1'b1);
    chk("busy_holds", 32'(ce), 1);
    repeat (25) step(1'b0, 1'b0, 1'b0);

    // WAKE during STOP: restart right after the stop ACK.
    repeat (8) step(1'b1, 1'b0, 1'b0);
    repeat (17) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-ON drops outputs without waiting for an edge.
    repeat (8) step(1'b1, 1'b0, 1'b0);
    @(negedge c);
    req_on = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("async_clr_ce", 32'(ce), 0);
    chk("async_clr_running", 32'(running), 0);
    chk("async_clr_ack", 32'(ack), 0);
    repeat (2) @(posedge c);
    @(negedge c);
    clr = 1'b0;
    model_reset();
    prev_ack = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // Randomized segments with varied traffic profiles.
    for (int seg = 0; seg < 60; seg++) begin
      mode = int'($urandom_range(0, 4));
      for (int i = 0; i < 30; i++) begin
        r = 1'b0; w = 1'b0; b = 1'b0;
        case (mode)
          0: w = ($urandom_range(0, 39) == 0);
          1: r = ($urandom_range(0, 9) != 0);
          2: w = ($urandom_range(0, 19) == 0);
          3: b = ($urandom_range(0, 19) != 0);
          default: begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
          end
        endcase
        step(r, w, b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
